// File: rtl/lvds_in_aligner_if.sv
// ---------------------------------------------------------------------------
// lvds_in_aligner_if
//   Bundles the serial input, realign request and aligned-word outputs of
//   lvds_in_aligner. The clock and reset are plain ports on the aligner.
//
//   data_in_from_pins   : sampled serial bit, one per clk_in rising edge
//   realign             : synchronous pulse, forces re-acquisition
//   data_out_to_device  : aligned word, MSB = first received bit
//   data_valid          : one-cycle strobe qualifying data_out_to_device
//   locked              : high while the aligner is locked
//
//   slave  : aligner side (consumes bits, drives the word outputs)
//   master : sampler / consumer side
// ---------------------------------------------------------------------------
interface lvds_in_aligner_if #(
    parameter int WORD_W = 8
);
    logic              data_in_from_pins;
    logic              realign;
    logic [WORD_W-1:0] data_out_to_device;
    logic              data_valid;
    logic              locked;

    modport slave (
        input  data_in_from_pins,
        input  realign,
        output data_out_to_device,
        output data_valid,
        output locked
    );

    modport master (
        output data_in_from_pins,
        output realign,
        input  data_out_to_device,
        input  data_valid,
        input  locked
    );
endinterface

// File: rtl/lvds_in_aligner.sv
// ---------------------------------------------------------------------------
// lvds_in_aligner
//   Recovers the word boundary of a single-lane serial stream (MSB first) by
//   hunting for TRAIN_PATTERN, verifying LOCK_CNT further boundary-aligned
//   copies, then delivering every aligned word with a one-cycle valid strobe.
//
//   Ports:
//     clk_in      : bit clock, one serial bit per rising edge
//     io_reset_n  : asynchronous active-low reset
//     bus (slave) : data_in_from_pins, realign in;
//                   data_out_to_device, data_valid, locked out (registered)
// ---------------------------------------------------------------------------
module lvds_in_aligner #(
    parameter int                WORD_W        = 8,
    parameter logic [WORD_W-1:0] TRAIN_PATTERN = 8'h5C,
    parameter int                LOCK_CNT      = 4
) (
    input  logic              clk_in,
    input  logic              io_reset_n,
    lvds_in_aligner_if.slave  bus
);

    localparam int            CW         = $clog2(WORD_W);
    localparam int            MW         = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] LAST       = CW'(WORD_W - 1);
    localparam logic [MW-1:0] MATCH_DONE = MW'(LOCK_CNT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            r_state,  w_state_nxt;
    logic [WORD_W-2:0] r_sr;
    logic [CW-1:0]     r_fill,   w_fill_nxt;
    logic [CW-1:0]     r_phase,  w_phase_nxt;
    logic [MW-1:0]     r_match,  w_match_nxt;
    logic [WORD_W-1:0] r_dout,   w_dout_nxt;
    logic              r_valid,  w_valid_nxt;
    logic              r_locked, w_locked_nxt;

    logic [WORD_W-1:0] w_word;
    logic              w_filled;
    logic              w_boundary;
    logic              w_is_train;

    // The candidate word includes this cycle's bit, so the shift register only
    // needs WORD_W-1 bits; its next value is simply the low bits of the word.
    assign w_word     = {r_sr, bus.data_in_from_pins};
    // Matching is gated until a full word of real bits has arrived, so the
    // zeros left in the shift register by reset/realign can never match.
    assign w_filled   = (r_fill == LAST);
    assign w_boundary = (r_phase == LAST);
    assign w_is_train = (w_word == TRAIN_PATTERN);

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = w_filled ? r_fill : r_fill + 1'b1;
        w_phase_nxt = w_boundary ? '0 : r_phase + 1'b1;
        w_match_nxt = r_match;
        w_dout_nxt  = r_dout;
        w_valid_nxt = 1'b0;

        unique case (r_state)
            HUNT: begin
                // Phase 0 next cycle puts the next boundary WORD_W cycles out.
                if (w_filled && w_is_train) begin
                    w_state_nxt = VERIFY;
                    w_phase_nxt = '0;
                    w_match_nxt = '0;
                end
            end
            VERIFY: begin
                if (w_boundary) begin
                    if (w_is_train) begin
                        w_match_nxt = r_match + 1'b1;
                        if (w_match_nxt == MATCH_DONE) begin
                            w_state_nxt = LOCKED;
                        end
                    end else begin
                        // Fill is kept, so hunting resumes on the next bit.
                        w_state_nxt = HUNT;
                    end
                end
            end
            LOCKED: begin
                if (w_boundary) begin
                    w_dout_nxt  = w_word;
                    w_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = HUNT;
            end
        endcase

        // Realign overrides anything decided above, including a boundary
        // capture in LOCKED: the output word simply holds.
        if (bus.realign) begin
            w_state_nxt = HUNT;
            w_fill_nxt  = '0;
            w_phase_nxt = '0;
            w_match_nxt = '0;
            w_dout_nxt  = r_dout;
            w_valid_nxt = 1'b0;
        end

        w_locked_nxt = (w_state_nxt == LOCKED);
    end

    always_ff @(posedge clk_in or negedge io_reset_n) begin
        if (!io_reset_n) begin
            r_state  <= HUNT;
            r_sr     <= '0;
            r_fill   <= '0;
            r_phase  <= '0;
            r_match  <= '0;
            r_dout   <= '0;
            r_valid  <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sr     <= w_word[WORD_W-2:0];
            r_fill   <= w_fill_nxt;
            r_phase  <= w_phase_nxt;
            r_match  <= w_match_nxt;
            r_dout   <= w_dout_nxt;
            r_valid  <= w_valid_nxt;
            r_locked <= w_locked_nxt;
        end
    end

    assign bus.data_out_to_device = r_dout;
    assign bus.data_valid         = r_valid;
    assign bus.locked             = r_locked;

endmodule

// File: tb/tb_lvds_in_aligner.sv
// ---------------------------------------------------------------------------
// tb_lvds_in_aligner
//   Each run builds a complete bit/realign stream up front. A reference model
//   walks that stream with the aligner's rules (find a training word once a
//   full word has arrived, check LOCK_CNT boundary copies, then emit every
//   following boundary word) and queues the expected strobes and the
//   expected locked level per cycle. The driver replays the stream; an
//   independent monitor compares DUT outputs against the queue/array.
//   A second instance with TRAIN_PATTERN = 0 is fed zeros from reset.
// ---------------------------------------------------------------------------
module tb_lvds_in_aligner;

    localparam int         W    = 8;
    localparam logic [7:0] TP   = 8'h5C;
    localparam int         LC   = 4;
    localparam int         MAXN = 512;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } ev_t;

    logic clk_in = 1'b0;
    logic io_reset_n = 1'b0;
    always #5 clk_in = ~clk_in;

    lvds_in_aligner_if #(.WORD_W(W)) bus ();
    lvds_in_aligner_if #(.WORD_W(W)) bus0 ();

    lvds_in_aligner #(.WORD_W(W), .TRAIN_PATTERN(TP), .LOCK_CNT(LC)) u_dut (
        .clk_in     (clk_in),
        .io_reset_n (io_reset_n),
        .bus        (bus)
    );

    lvds_in_aligner #(.WORD_W(W), .TRAIN_PATTERN(8'h00), .LOCK_CNT(LC)) u_dut0 (
        .clk_in     (clk_in),
        .io_reset_n (io_reset_n),
        .bus        (bus0)
    );

    int   ntests = 0;
    int   nfail  = 0;
    bit   stim_b [MAXN];
    bit   stim_r [MAXN];
    bit   exp_lock [MAXN+1];
    int   n;
    ev_t  exp_q [$];
    int   tcyc;
    int   run_id = 0;
    bit   mon_en = 1'b0;
    logic [7:0] hold;
    int   first_lock, first_dv;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- stimulus construction ----------------
    task automatic clr_stim();
        n = 0;
        for (int i = 0; i < MAXN; i++) begin
            stim_b[i] = 1'b0;
            stim_r[i] = 1'b0;
        end
    endtask

    task automatic push_bit(input bit b);
        stim_b[n] = b;
        n++;
    endtask

    task automatic push_word(input logic [7:0] w);
        for (int i = W - 1; i >= 0; i--) push_bit(w[i]);
    endtask

    function automatic logic [7:0] word_at(input int c);
        logic [7:0] v;
        for (int i = 0; i < W; i++) v[W-1-i] = stim_b[c-W+1+i];
        return v;
    endfunction

    // ---------------- reference model ----------------
    // A stream splits into segments at realign cycles; the realign cycle
    // itself belongs to no segment and the next segment starts right after.
    task automatic build_model();
        int s, e, c, k, lk;
        exp_q.delete();
        for (int i = 0; i <= MAXN; i++) exp_lock[i] = 1'b0;
        s = 0;
        while (s < n) begin
            e = s;
            while (e < n && !stim_r[e]) e++;
            c = s + W - 1;
            while (c < e) begin
                if (word_at(c) == TP) begin
                    k = 1;
                    while (k <= LC && c + k*W < e && word_at(c + k*W) == TP) k++;
                    if (k > LC) begin
                        lk = c + LC*W;
                        for (int x = lk + 1; x <= e; x++) exp_lock[x] = 1'b1;
                        for (int b = lk + W; b < e; b += W) exp_q.push_back('{b + 1, word_at(b)});
                        c = e;
                    end else if (c + k*W < e) begin
                        c = c + k*W + 1;
                    end else begin
                        c = e;
                    end
                end else begin
                    c++;
                end
            end
            s = e + 1;
        end
    endtask

    // ---------------- driver ----------------
    // Reset is held on entry and released on the same edge that presents bit 0.
    task automatic run();
        build_model();
        run_id++;
        hold       = 8'h00;
        first_lock = -1;
        first_dv   = -1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk_in);
            io_reset_n = 1'b1;
            bus.data_in_from_pins = stim_b[k];
            bus.realign           = stim_r[k];
            tcyc   = k;
            mon_en = 1'b1;
        end
        @(posedge clk_in);
        #2;
        mon_en = 1'b0;
        bus.realign = 1'b0;
        chk("strobes_all_seen", exp_q.size(), 0);
    endtask

    task automatic hard_reset();
        @(negedge clk_in);
        io_reset_n  = 1'b0;
        bus.realign = 1'b0;
        @(negedge clk_in);
    endtask

    // ---------------- monitor ----------------
    int  cy;
    ev_t ev;
    always @(posedge clk_in) begin
        #1;
        if (mon_en) begin
            cy = tcyc + 1;
            chk("locked", bus.locked, exp_lock[cy]);
            if (bus.data_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe_cycle", cy, 0);
                end else begin
                    ev = exp_q.pop_front();
                    chk("strobe_cycle", cy, ev.cyc);
                    chk("strobe_data", bus.data_out_to_device, ev.val);
                end
                hold = bus.data_out_to_device;
                if (first_dv < 0) first_dv = cy;
            end else begin
                chk("data_hold", bus.data_out_to_device, hold);
            end
            if (bus.locked && first_lock < 0) first_lock = cy;
            if (run_id == 1 && cy <= 48) begin
                chk("tp00_locked", bus0.locked, (cy >= 40));
                chk("tp00_valid", bus0.data_valid, (cy == 48));
                if (cy == 48) chk("tp00_data", bus0.data_out_to_device, 8'h00);
            end
        end
    end

    // ---------------- stimulus generators ----------------
    task automatic gen_acq_payload();
        clr_stim();
        push_bit(1); push_bit(1); push_bit(1);
        repeat (6) push_word(TP);
        push_word(8'hA1); push_word(8'h3C); push_word(8'hFF);
    endtask

    task automatic gen_verify_fail();
        clr_stim();
        repeat (3) push_word(TP);
        push_word(8'h00);
        repeat (6) push_word(TP);
    endtask

    task automatic gen_realign();
        clr_stim();
        push_bit(1); push_bit(1); push_bit(1);
        repeat (14) push_word(TP);
        stim_r[50] = 1'b1;
    endtask

    task automatic gen_random();
        logic [7:0] w;
        clr_stim();
        for (int seg = 0; seg < 3; seg++) begin
            repeat ($urandom_range(0, 12)) push_bit(1'($urandom_range(0, 1)));
            repeat ($urandom_range(3, 7)) begin
                w = TP;
                if ($urandom_range(0, 9) == 0) w = 8'($urandom);
                push_word(w);
            end
            repeat ($urandom_range(2, 6)) push_word(8'($urandom));
            if (seg < 2) stim_r[n - 1 - $urandom_range(0, 9)] = 1'b1;
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        bus.data_in_from_pins  = 1'b0;
        bus.realign            = 1'b0;
        bus0.data_in_from_pins = 1'b0;
        bus0.realign           = 1'b0;

        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_locked", bus.locked, 0);
        chk("rst_valid", bus.data_valid, 0);
        chk("rst_data", bus.data_out_to_device, 0);

        // Acquisition with a 3-bit offset, then payload.
        gen_acq_payload();
        run();
        chk("acq_first_lock", first_lock, 43);
        chk("acq_first_strobe", first_dv, 51);

        // Reset mid-word while locked: outputs clear without a clock edge.
        @(posedge clk_in);
        #3;
        io_reset_n = 1'b0;
        #1;
        chk("async_rst_locked", bus.locked, 0);
        chk("async_rst_valid", bus.data_valid, 0);
        chk("async_rst_data", bus.data_out_to_device, 0);
        repeat (2) @(negedge clk_in);
        chk("rst_hold_locked", bus.locked, 0);
        chk("rst_hold_data", bus.data_out_to_device, 0);

        gen_verify_fail();
        run();
        chk("vfail_first_lock", first_lock, 72);

        hard_reset();
        gen_realign();
        run();
        chk("realign_first_lock", first_lock, 43);
        chk("realign_first_strobe", first_dv, 99);

        for (int r = 0; r < 4; r++) begin
            hard_reset();
            gen_random();
            run();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
